// File: rtl/regfile_pkg.sv
// +-----------------------------------------------------------------------+
// | regfile_pkg : register-file geometry shared by writeback and storage  |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int PC_IDX   = 15;

  // Index visited k steps after 'last' in a circular scan of n requesters.
  function automatic int rr_index(input int last, input int k, input int n);
    return (last + k) % n;
  endfunction
endpackage

`default_nettype wire

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// +-----------------------------------------------------------------------+
// | rr_arbiter : round-robin arbiter, one-hot grant, pointer moves on     |
// |              every grant (a grant is only ever given to a valid req)  |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] r_last;
  logic [PTR_W-1:0] w_next;
  logic             w_any;

  always_comb begin
    grant  = '0;
    w_next = r_last;
    w_any  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_any && req[rr_index(int'(r_last), k, NUM_REQ)]) begin
        grant[rr_index(int'(r_last), k, NUM_REQ)] = 1'b1;
        w_next = PTR_W'(rr_index(int'(r_last), k, NUM_REQ));
        w_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= '0;
    end else if (w_any) begin
      r_last <= w_next;
    end
  end
endmodule

`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
// +-----------------------------------------------------------------------+
// | regfile_wb_scheduler : arbitrates writeback sources onto the single   |
// |   register-file write port and keeps the RAW/WAW busy scoreboard      |
// | Revision             : 1.0                                            |
// +-----------------------------------------------------------------------+
`default_nettype none

module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      iss_valid,
  input  logic                      iss_has_dst,
  input  logic [ADDR_W-1:0]         iss_dst,
  input  logic [ADDR_W-1:0]         iss_src1,
  input  logic [ADDR_W-1:0]         iss_src2,
  output logic                      iss_stall,
  output logic [NUM_REGS-1:0]       busy_vec
);
  localparam logic [ADDR_W-1:0] C_PC = ADDR_W'(PC_IDX);

  logic [NUM_REQ-1:0]  w_grant;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_hs;
  logic                w_set;
  logic                w_src1_busy;
  logic                w_src2_busy;
  logic                w_dst_busy;
  logic [NUM_REGS-1:0] r_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_hs      = |w_grant;

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // PC writes are accepted from the source but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= w_hs && (w_addr != C_PC);
      if (w_hs) begin
        rf_waddr <= w_addr;
        rf_wdata <= w_data;
      end
    end
  end

  assign w_src1_busy = (iss_src1 != C_PC) && r_busy[iss_src1];
  assign w_src2_busy = (iss_src2 != C_PC) && r_busy[iss_src2];
  assign w_dst_busy  = iss_has_dst && r_busy[iss_dst];
  assign iss_stall   = iss_valid && (w_src1_busy || w_src2_busy || w_dst_busy);
  assign w_set       = iss_valid && !iss_stall && iss_has_dst && (iss_dst != C_PC);

  // Later assignment wins, so a same-cycle set overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (rf_we) r_busy[rf_waddr] <= 1'b0;
      if (w_set) r_busy[iss_dst]  <= 1'b1;
    end
  end

  assign busy_vec = r_busy;
endmodule

`default_nettype wire
